hazard_stall_unit: RTL and testbench

- Produces the HazMuxCon select consumed by the next-address mux (0 = PC+2, 1 = PC+0).
- Also produces the IF/ID write-enable, IF/ID flush and ID/EX bubble controls.
- Detects load-use hazards between ID/EX and IF/ID, sequences multi-cycle branch flushes, and holds the pipeline frozen after a halt.
- Keeps a saturating stall-cycle counter for performance observation.

---
 rtl/hazard_stall_unit.sv | 136 +++++++++++++
 tb/tb_hazard_stall_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   Generates the pipeline control signals for the front end of the pipeline:
//   it detects load-use hazards, sequences branch flushes and freezes the
//   pipeline after a halt. It also keeps a saturating count of stall cycles.
//
// Ports
//   clk, rst       rising-edge clock; asynchronous active-low reset
//   idex_memread   the ID/EX instruction is a load
//   idex_rd        destination register of the ID/EX instruction
//   ifid_rs/rt     source registers of the IF/ID instruction
//   ifid_uses_rt   the IF/ID instruction actually reads rt
//   branch_taken   a branch resolved taken this cycle
//   halt_in        a halt is decoded in IF/ID
//   HazMuxCon      next-address select: 1 = hold PC (+0), 0 = advance (+2)
//   ifid_write     IF/ID load enable
//   ifid_flush     zero the IF/ID register
//   idex_bubble    zero the control bits entering ID/EX
//   halted         the unit is frozen in HALT
//   stall_count    saturating count of cycles with HazMuxCon=1
module hazard_stall_unit #(
   parameter int REG_ADDR_W   = 4,
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  idex_memread,
   input  logic [REG_ADDR_W-1:0] idex_rd,
   input  logic [REG_ADDR_W-1:0] ifid_rs,
   input  logic [REG_ADDR_W-1:0] ifid_rt,
   input  logic                  ifid_uses_rt,
   input  logic                  branch_taken,
   input  logic                  halt_in,
   output logic                  HazMuxCon,
   output logic                  ifid_write,
   output logic                  ifid_flush,
   output logic                  idex_bubble,
   output logic                  halted,
   output logic [CNT_W-1:0]      stall_count
);

   typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

   // The branch cycle itself is the first flush cycle, so the counter only
   // covers the remaining ones.
   localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

   state_t     state_q, state_d;
   logic [2:0] fcnt_q, fcnt_d;
   logic       load_use;
   logic       hold_c, wr_c, flush_c, bubble_c, halted_c;

   // Register 0 is deliberately not exempt.
   assign load_use = idex_memread &&
                     ((idex_rd == ifid_rs) || (ifid_uses_rt && (idex_rd == ifid_rt)));

   always_comb begin
      state_d  = state_q;
      fcnt_d   = fcnt_q;
      hold_c   = 1'b0;
      wr_c     = 1'b1;
      flush_c  = 1'b0;
      bubble_c = 1'b0;
      halted_c = 1'b0;
      case (state_q)
         RUN: begin
            if (branch_taken) begin
               flush_c  = 1'b1;
               bubble_c = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  state_d = FLUSH;
                  fcnt_d  = FLUSH_RELOAD;
               end
            end else if (halt_in) begin
               hold_c   = 1'b1;
               wr_c     = 1'b0;
               bubble_c = 1'b1;
               state_d  = HALT;
            end else if (load_use) begin
               // Single-cycle stall: the load moves on, so the hazard clears.
               hold_c   = 1'b1;
               wr_c     = 1'b0;
               bubble_c = 1'b1;
            end
         end
         FLUSH: begin
            flush_c  = 1'b1;
            bubble_c = 1'b1;
            if (branch_taken) begin
               fcnt_d = FLUSH_RELOAD;   // a newer branch restarts the flush
            end else if (fcnt_q == 3'd1) begin
               state_d = RUN;
               fcnt_d  = 3'd0;
            end else begin
               fcnt_d = fcnt_q - 3'd1;
            end
         end
         HALT: begin
            hold_c   = 1'b1;
            wr_c     = 1'b0;
            bubble_c = 1'b1;
            halted_c = 1'b1;
         end
         default: begin
            state_d = RUN;
            fcnt_d  = 3'd0;
         end
      endcase
   end

   // Outputs are forced to RUN-idle while reset is held, independent of the
   // (already cleared) state, so they drop in the same cycle reset asserts.
   assign HazMuxCon   = rst & hold_c;
   assign ifid_write  = ~rst | wr_c;
   assign ifid_flush  = rst & flush_c;
   assign idex_bubble = rst & bubble_c;
   assign halted      = rst & halted_c;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RUN;
         fcnt_q  <= 3'd0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stall_count <= '0;
      else if (HazMuxCon && (stall_count != '1))
         stall_count <= stall_count + 1'b1;
   end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Testbench for hazard_stall_unit: directed scenarios followed by random
// stimulus, all compared against a cycle-level behavioural model.
module tb_hazard_stall_unit;

   localparam int RW     = 4;
   localparam int FC     = 3;
   localparam int CW     = 4;
   localparam int CNTMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          idex_memread = 1'b0;
   logic [RW-1:0] idex_rd = '0, ifid_rs = '0, ifid_rt = '0;
   logic          ifid_uses_rt = 1'b0, branch_taken = 1'b0, halt_in = 1'b0;
   logic          HazMuxCon, ifid_write, ifid_flush, idex_bubble, halted;
   logic [CW-1:0] stall_count;

   hazard_stall_unit #(.REG_ADDR_W(RW), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .idex_memread(idex_memread), .idex_rd(idex_rd),
      .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
      .branch_taken(branch_taken), .halt_in(halt_in),
      .HazMuxCon(HazMuxCon), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .halted(halted), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: number of flush cycles still owed after the current
   // one, a sticky halt flag and a plain integer stall counter.
   int m_rem  = 0;
   bit m_halt = 1'b0;
   int m_cnt  = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " hold"},   int'(HazMuxCon),   0);
      chk({tag, " wr"},     int'(ifid_write),  1);
      chk({tag, " flush"},  int'(ifid_flush),  0);
      chk({tag, " bubble"}, int'(idex_bubble), 0);
      chk({tag, " halted"}, int'(halted),      0);
   endtask

   // Entered and left at posedge+1. Applies one cycle of inputs, checks at
   // the falling edge, then advances the model across the rising edge.
   task automatic step(input bit mr, input int rd, input int rs, input int rt,
                       input bit ut, input bit br, input bit ht);
      bit lu, e_hold, e_wr, e_fl, e_bub, e_h, nx_halt;
      int nx_rem;
      idex_memread = mr;  idex_rd = RW'(rd); ifid_rs = RW'(rs); ifid_rt = RW'(rt);
      ifid_uses_rt = ut;  branch_taken = br; halt_in = ht;
      @(negedge clk);
      lu = mr && (rd == rs || (ut && rd == rt));
      e_hold = 0; e_wr = 1; e_fl = 0; e_bub = 0; e_h = 0;
      nx_rem = m_rem; nx_halt = m_halt;
      if (m_halt) begin
         e_hold = 1; e_wr = 0; e_bub = 1; e_h = 1;
      end else if (br || m_rem > 0) begin
         e_fl = 1; e_bub = 1;
         nx_rem = br ? FC - 1 : m_rem - 1;
      end else if (ht) begin
         e_hold = 1; e_wr = 0; e_bub = 1; nx_halt = 1;
      end else if (lu) begin
         e_hold = 1; e_wr = 0; e_bub = 1;
      end
      chk("HazMuxCon",   int'(HazMuxCon),   int'(e_hold));
      chk("ifid_write",  int'(ifid_write),  int'(e_wr));
      chk("ifid_flush",  int'(ifid_flush),  int'(e_fl));
      chk("idex_bubble", int'(idex_bubble), int'(e_bub));
      chk("halted",      int'(halted),      int'(e_h));
      chk("stall_count", int'(stall_count), m_cnt);
      @(posedge clk);
      m_rem = nx_rem; m_halt = nx_halt;
      if (e_hold && m_cnt < CNTMAX) m_cnt++;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 1, 2, 0, 0, 0);
   endtask

   // Asserts reset part-way through a cycle with a hazard still on the
   // inputs; outputs must go idle straight away.
   task automatic do_reset();
      idex_memread = 1; idex_rd = 3; ifid_rs = 3; halt_in = 0; branch_taken = 0;
      #2 rst = 1'b0;
      #1;
      chk_idle("rst async");
      chk("rst count", int'(stall_count), 0);
      m_rem = 0; m_halt = 0; m_cnt = 0;
      @(negedge clk);
      chk_idle("rst held");
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   initial begin
      // Reset, then idle.
      #1;
      do_reset();
      idle(5);
      chk("idle count", int'(stall_count), 0);

      // Load-use on rs: one stall cycle.
      step(1, 3, 3, 7, 0, 0, 0);
      idle(1);
      chk("lu rs count", int'(stall_count), 1);

      // rt only matters when it is actually read.
      step(1, 5, 0, 5, 0, 0, 0);
      step(1, 5, 0, 5, 1, 0, 0);
      idle(1);
      chk("lu rt count", int'(stall_count), 2);

      // Register 0 is not exempt.
      step(1, 0, 0, 9, 0, 0, 0);
      idle(1);
      chk("lu r0 count", int'(stall_count), 3);

      // Branch beats a simultaneous load-use; flush lasts FC cycles.
      step(1, 3, 3, 3, 1, 1, 0);
      step(1, 3, 3, 3, 1, 0, 1);
      step(1, 3, 3, 3, 1, 0, 0);
      idle(2);
      chk("branch count", int'(stall_count), 3);

      // Branch inside a flush restarts it.
      step(0, 0, 1, 2, 0, 1, 0);
      step(0, 0, 1, 2, 0, 1, 0);
      idle(4);

      // Halt, then 10 more cycles: 11 stall cycles.
      do_reset();
      step(0, 0, 1, 2, 0, 0, 1);
      for (int i = 0; i < 10; i++)
         step(1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom));
      chk("halt count", int'(stall_count), 11);
      chk("halt flag", int'(halted), 1);
      do_reset();
      chk("post-halt flag", int'(halted), 0);

      // Saturation.
      step(0, 0, 1, 2, 0, 0, 1);
      idle(20);
      chk("sat count", int'(stall_count), CNTMAX);

      // Random traffic with occasional resets.
      do_reset();
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 63) == 0) do_reset();
         step(1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), 1'($urandom),
              $urandom_range(0, 7) == 0, $urandom_range(0, 47) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
